// File: rtl/merge10_leaf_if.sv
// Handshake bundle for the two-input flit merger: two producer channels,
// one merged output channel and the source tag travelling with it.
interface merge10_leaf_if #(
    parameter int unsigned W = 9
);
    logic         In0_valid;
    logic         In0_ready;
    logic [W-1:0] In0_data;
    logic         In1_valid;
    logic         In1_ready;
    logic [W-1:0] In1_data;
    logic         Out_valid;
    logic         Out_ready;
    logic [W-1:0] Out_data;
    logic         S;

    modport slave (
        input  In0_valid, In0_data, In1_valid, In1_data, Out_ready,
        output In0_ready, In1_ready, Out_valid, Out_data, S
    );

    modport master (
        output In0_valid, In0_data, In1_valid, In1_data, Out_ready,
        input  In0_ready, In1_ready, Out_valid, Out_data, S
    );
endinterface

// File: rtl/merge10_leaf.sv
// Two-input flit merger: round-robin arbiter with optional packet lock,
// feeding a 2-entry output FIFO that carries {source, flit}.
module merge10_leaf #(
    parameter int unsigned W        = 9,
    parameter bit          PKT_LOCK = 1'b1
) (
    input logic           CLK,
    input logic           RESET,
    merge10_leaf_if.slave bus
);
    localparam int unsigned ENTRY_W = W + 1;

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t               state_q, state_d;
    logic                 last_q, last_d;
    logic [1:0]           count_q;
    logic                 rd_q, wr_q;
    logic [ENTRY_W-1:0]   mem_q [2];

    logic                 grant0, grant1;
    logic                 push0, push1, push, pop;
    logic                 src, tail;
    logic [W-1:0]         push_data;

    // Arbitration and lock tracking; nothing is granted while full or in reset.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant0  = 1'b0;
        grant1  = 1'b0;

        if (!RESET && count_q != 2'd2) begin
            case (state_q)
                LOCK0:   grant0 = 1'b1;
                LOCK1:   grant1 = 1'b1;
                default: begin
                    if (bus.In0_valid && bus.In1_valid) begin
                        grant0 = last_q;
                        grant1 = !last_q;
                    end else begin
                        grant0 = bus.In0_valid;
                        grant1 = bus.In1_valid;
                    end
                end
            endcase
        end

        push0     = grant0 & bus.In0_valid;
        push1     = grant1 & bus.In1_valid;
        push      = push0 | push1;
        src       = push1;
        push_data = push1 ? bus.In1_data : bus.In0_data;
        tail      = push_data[W-1];

        if (push) begin
            last_d = src;
            if (PKT_LOCK) begin
                if (state_q == IDLE) begin
                    if (!tail) state_d = src ? LOCK1 : LOCK0;
                end else if (tail) begin
                    state_d = IDLE;
                end
            end
        end
    end

    assign pop           = (count_q != 2'd0) && bus.Out_ready;
    assign bus.In0_ready = grant0;
    assign bus.In1_ready = grant1;
    assign bus.Out_valid = (count_q != 2'd0);
    assign bus.Out_data  = mem_q[rd_q][W-1:0];
    assign bus.S         = mem_q[rd_q][W];

    // Control state; last resets to 1 so In0 wins the first contention.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            count_q <= 2'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            count_q <= count_q + 2'(push) - 2'(pop);
            if (push) wr_q <= ~wr_q;
            if (pop)  rd_q <= ~rd_q;
        end
    end

    // FIFO storage needs no reset; contents are ignored while empty.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_q] <= {src, push_data};
    end
endmodule

// File: tb/tb_merge10_leaf.sv
// Randomised self-checking bench for merge10_leaf against a queue-based
// reference model; covers both packet-lock and per-flit arbitration builds.
module tb_merge10_leaf;
    localparam int unsigned W = 9;

    logic CLK = 1'b0;
    logic rst;
    logic mode;          // 0: packet-lock instance, 1: per-flit instance
    logic ordy;
    logic vv [2];
    logic [W-1:0] dd [2];

    always #5 CLK = ~CLK;

    merge10_leaf_if #(.W(W)) ifl ();
    merge10_leaf_if #(.W(W)) ifn ();

    assign ifl.In0_valid = !mode & vv[0];
    assign ifl.In1_valid = !mode & vv[1];
    assign ifl.In0_data  = dd[0];
    assign ifl.In1_data  = dd[1];
    assign ifl.Out_ready = !mode & ordy;
    assign ifn.In0_valid = mode & vv[0];
    assign ifn.In1_valid = mode & vv[1];
    assign ifn.In0_data  = dd[0];
    assign ifn.In1_data  = dd[1];
    assign ifn.Out_ready = mode & ordy;

    merge10_leaf #(.W(W), .PKT_LOCK(1'b1)) dut_l (.CLK(CLK), .RESET(rst), .bus(ifl.master));
    merge10_leaf #(.W(W), .PKT_LOCK(1'b0)) dut_n (.CLK(CLK), .RESET(rst), .bus(ifn.master));

    logic         ob_r0, ob_r1, ob_ov, ob_s;
    logic [W-1:0] ob_d;
    assign ob_r0 = mode ? ifn.In0_ready : ifl.In0_ready;
    assign ob_r1 = mode ? ifn.In1_ready : ifl.In1_ready;
    assign ob_ov = mode ? ifn.Out_valid : ifl.Out_valid;
    assign ob_s  = mode ? ifn.S         : ifl.S;
    assign ob_d  = mode ? ifn.Out_data  : ifl.Out_data;

    // Reference model: buffered flits, lock owner (-1 none), last winner.
    logic [W:0] q [$];
    int         lock;
    logic       last;
    logic       xf [2];
    int         rem [2];
    int         obs_acc [2];
    int         n_pop;
    logic       pop_log [$];
    int         n_pass = 0;
    int         n_total = 0;

    function automatic logic exp_rdy(input int i);
        if (rst || q.size() >= 2) return 1'b0;
        if (lock >= 0) return lock == i;
        if (!vv[i]) return 1'b0;
        if (!vv[1-i]) return 1'b1;
        return last != 1'(i);
    endfunction

    task automatic tick();
        logic e [2];
        e[0] = exp_rdy(0);
        e[1] = exp_rdy(1);
        if (ob_ov && ordy) begin
            pop_log.push_back(ob_s);
            n_pop++;
        end
        if (vv[0] && ob_r0) obs_acc[0]++;
        if (vv[1] && ob_r1) obs_acc[1]++;
        @(posedge CLK);
        for (int i = 0; i < 2; i++) xf[i] = vv[i] && e[i];
        if (rst) begin
            q.delete();
            lock = -1;
            last = 1'b1;
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            for (int i = 0; i < 2; i++) begin
                if (xf[i]) begin
                    q.push_back({1'(i), dd[i]});
                    if (!mode) begin
                        if (lock < 0 && !dd[i][W-1]) lock = i;
                        else if (lock == i && dd[i][W-1]) lock = -1;
                    end
                    last = 1'(i);
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vv[0] = 1'b0;
        vv[1] = 1'b0;
        rem[0] = 0;
        rem[1] = 0;
        tick();
        rst = 1'b0;
        pop_log.delete();
    endtask

    task automatic next_flit(input int i, input int pct);
        if (int'($urandom_range(99)) < pct) begin
            if (rem[i] == 0) rem[i] = int'($urandom_range(1, 4));
            dd[i] = {rem[i] == 1, (W-1)'($urandom)};
            rem[i]--;
            vv[i] = 1'b1;
        end else begin
            vv[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ordy = 1'b1;
        vv[0] = 1'b1; vv[1] = 1'b1;
        dd[0] = {1'b1, 8'h11}; dd[1] = {1'b1, 8'h22};
        for (int k = 0; k < 2; k++) begin
            tick();
            #1;
            n_total++;
            if ({ob_r0, ob_r1, ob_ov} !== 3'b000) $display("FAIL reset r0r1v got=%b exp=000", {ob_r0, ob_r1, ob_ov});
            else n_pass++;
        end
        do_reset();
    endtask

    task automatic test_alternate();
        do_reset();
        ordy = 1'b1;
        for (int i = 0; i < 2; i++) begin vv[i] = 1'b1; dd[i] = {1'b1, (W-1)'($urandom)}; end
        for (int k = 0; k < 16; k++) begin
            #1;
            n_total++;
            if ({ob_r0, ob_r1, ob_ov} !== {exp_rdy(0), exp_rdy(1), q.size() != 0})
                $display("FAIL alternate ctl got=%b exp=%b", {ob_r0, ob_r1, ob_ov}, {exp_rdy(0), exp_rdy(1), q.size() != 0});
            else n_pass++;
            if (q.size() > 0) begin
                n_total++;
                if ({ob_s, ob_d} !== q[0]) $display("FAIL alternate out got=%h exp=%h", {ob_s, ob_d}, q[0]);
                else n_pass++;
            end
            tick();
            for (int i = 0; i < 2; i++) if (xf[i]) dd[i] = {1'b1, (W-1)'($urandom)};
        end
        n_total++;
        if (pop_log.size() != 15 || pop_log[0] !== 1'b0) $display("FAIL alternate pops got=%0d/S%b exp=15/S0", pop_log.size(), pop_log[0]);
        else n_pass++;
        for (int k = 1; k < pop_log.size(); k++) begin
            n_total++;
            if (pop_log[k] !== ~pop_log[k-1]) $display("FAIL alternate seq idx=%0d got=%b exp=%b", k, pop_log[k], ~pop_log[k-1]);
            else n_pass++;
        end
    endtask

    task automatic test_lock();
        int sent = 0;
        logic exp_s [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        ordy = 1'b1;
        vv[0] = 1'b1; dd[0] = {1'b0, (W-1)'($urandom)};
        vv[1] = 1'b1; dd[1] = {1'b1, (W-1)'($urandom)};
        for (int k = 0; k < 8; k++) begin
            #1;
            n_total++;
            if ({ob_r0, ob_r1, ob_ov} !== {exp_rdy(0), exp_rdy(1), q.size() != 0})
                $display("FAIL lock ctl got=%b exp=%b", {ob_r0, ob_r1, ob_ov}, {exp_rdy(0), exp_rdy(1), q.size() != 0});
            else n_pass++;
            if (q.size() > 0) begin
                n_total++;
                if ({ob_s, ob_d} !== q[0]) $display("FAIL lock out got=%h exp=%h", {ob_s, ob_d}, q[0]);
                else n_pass++;
            end
            tick();
            if (xf[0]) begin
                sent++;
                if (sent < 3) dd[0] = {sent == 2, (W-1)'($urandom)};
                else vv[0] = 1'b0;
            end
            if (xf[1]) dd[1] = {1'b1, (W-1)'($urandom)};
        end
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (pop_log.size() <= k || pop_log[k] !== exp_s[k])
                $display("FAIL lock order idx=%0d got=%b exp=%b", k, (pop_log.size() > k) ? pop_log[k] : 1'bx, exp_s[k]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int base_a, base_p;
        do_reset();
        ordy = 1'b0;
        vv[0] = 1'b1; dd[0] = {1'b1, (W-1)'($urandom)};
        base_a = obs_acc[0];
        for (int k = 0; k < 10; k++) begin
            if (k == 6) begin ordy = 1'b1; vv[0] = 1'b0; base_p = n_pop; end
            #1;
            n_total++;
            if ({ob_r0, ob_r1, ob_ov} !== {exp_rdy(0), exp_rdy(1), q.size() != 0})
                $display("FAIL backpressure ctl got=%b exp=%b", {ob_r0, ob_r1, ob_ov}, {exp_rdy(0), exp_rdy(1), q.size() != 0});
            else n_pass++;
            if (q.size() > 0) begin
                n_total++;
                if ({ob_s, ob_d} !== q[0]) $display("FAIL backpressure out got=%h exp=%h", {ob_s, ob_d}, q[0]);
                else n_pass++;
            end
            tick();
            if (xf[0]) dd[0] = {1'b1, (W-1)'($urandom)};
        end
        n_total++;
        if (obs_acc[0] - base_a != 2) $display("FAIL backpressure accepts got=%0d exp=2", obs_acc[0] - base_a);
        else n_pass++;
        n_total++;
        if (n_pop - base_p != 2) $display("FAIL backpressure drain got=%0d exp=2", n_pop - base_p);
        else n_pass++;
    endtask

    task automatic test_throughput();
        int base_a, base_p;
        do_reset();
        ordy = 1'b1;
        vv[0] = 1'b1; dd[0] = {1'b1, (W-1)'($urandom)};
        tick();
        if (xf[0]) dd[0] = {1'b1, (W-1)'($urandom)};
        base_a = obs_acc[0];
        base_p = n_pop;
        for (int k = 0; k < 12; k++) begin
            #1;
            n_total++;
            if ({ob_r0, ob_r1, ob_ov} !== {exp_rdy(0), exp_rdy(1), q.size() != 0})
                $display("FAIL throughput ctl got=%b exp=%b", {ob_r0, ob_r1, ob_ov}, {exp_rdy(0), exp_rdy(1), q.size() != 0});
            else n_pass++;
            if (q.size() > 0) begin
                n_total++;
                if ({ob_s, ob_d} !== q[0]) $display("FAIL throughput out got=%h exp=%h", {ob_s, ob_d}, q[0]);
                else n_pass++;
            end
            tick();
            if (xf[0]) dd[0] = {1'b1, (W-1)'($urandom)};
        end
        n_total++;
        if (obs_acc[0] - base_a != 12 || n_pop - base_p != 12)
            $display("FAIL throughput rate got=%0d/%0d exp=12/12", obs_acc[0] - base_a, n_pop - base_p);
        else n_pass++;
    endtask

    task automatic test_reset_lock();
        do_reset();
        ordy = 1'b0;
        vv[1] = 1'b1; dd[1] = {1'b0, (W-1)'($urandom)};
        for (int k = 0; k < 3; k++) begin
            tick();
            if (xf[1]) dd[1] = {1'b0, (W-1)'($urandom)};
        end
        n_total++;
        if (q.size() != 2 || lock != 1 || {ob_r0, ob_r1} !== 2'b00)
            $display("FAIL reset_lock setup got=%b exp=00", {ob_r0, ob_r1});
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vv[0] = 1'b1; dd[0] = {1'b1, 8'hA5};
        vv[1] = 1'b1; dd[1] = {1'b1, 8'h5A};
        #1;
        n_total++;
        if ({ob_r0, ob_r1, ob_ov} !== 3'b100) $display("FAIL reset_lock after got=%b exp=100", {ob_r0, ob_r1, ob_ov});
        else n_pass++;
        tick();
    endtask

    task automatic test_random(input string name, input logic nolock, input int cycles);
        mode = nolock;
        do_reset();
        for (int i = 0; i < 2; i++) next_flit(i, 80);
        for (int k = 0; k < cycles; k++) begin
            ordy = (int'($urandom_range(99)) < 65);
            #1;
            n_total++;
            if ({ob_r0, ob_r1, ob_ov} !== {exp_rdy(0), exp_rdy(1), q.size() != 0})
                $display("FAIL %s ctl cyc=%0d got=%b exp=%b", name, k, {ob_r0, ob_r1, ob_ov}, {exp_rdy(0), exp_rdy(1), q.size() != 0});
            else n_pass++;
            if (q.size() > 0) begin
                n_total++;
                if ({ob_s, ob_d} !== q[0]) $display("FAIL %s out cyc=%0d got=%h exp=%h", name, k, {ob_s, ob_d}, q[0]);
                else n_pass++;
            end
            tick();
            for (int i = 0; i < 2; i++) if (xf[i] || !vv[i]) next_flit(i, 80);
        end
    endtask

    initial begin
        mode = 1'b0; rst = 1'b1; ordy = 1'b0;
        vv[0] = 1'b0; vv[1] = 1'b0; dd[0] = '0; dd[1] = '0;
        lock = -1; last = 1'b1; n_pop = 0;
        obs_acc[0] = 0; obs_acc[1] = 0; rem[0] = 0; rem[1] = 0;
        @(negedge CLK);
        test_reset();
        test_alternate();
        test_lock();
        test_backpressure();
        test_throughput();
        test_reset_lock();
        test_random("random_nolock", 1'b1, 400);
        test_random("random_lock", 1'b0, 400);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/merge10_leaf.md
MERGE10_LEAF -- requirements
Module: merge10_leaf

Interface
REQ-001 Parameter: W, default 9, flit width in bits; bit W-1 is the tail flag.
REQ-002 Parameter: PKT_LOCK, default 1; 1 = grant held for a whole packet, 0 = arbitration on every flit.
REQ-003 Port: CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: RESET  input  1  reset, synchronous to CLK, active-high.
REQ-005 Port: In0_valid  input  1  flit offered on input 0.
REQ-006 Port: In0_ready  output  1  input 0 flit accepted this cycle when valid is also high.
REQ-007 Port: In0_data  input  W  input 0 flit.
REQ-008 Port: In1_valid  input  1  flit offered on input 1.
REQ-009 Port: In1_ready  output  1  input 1 flit accepted this cycle when valid is also high.
REQ-010 Port: In1_data  input  W  input 1 flit.
REQ-011 Port: Out_valid  output  1  merged flit available.
REQ-012 Port: Out_ready  input  1  downstream takes the flit when valid is also high.
REQ-013 Port: Out_data  output  W  merged flit.
REQ-014 Port: S  output  1  source of the current Out flit (0 = In0, 1 = In1); qualified by Out_valid; moves with Out_data.

Function
REQ-015 A transfer on any channel occurs exactly when valid and ready are both high at a rising CLK edge.
REQ-016 Producers shall hold valid and data stable until the transfer occurs; the block does not check this.
REQ-017 Output stage: 2-entry FIFO holding {S, data}; Out_valid = (count > 0); Out_data and S come from the head entry.
REQ-018 At most one input flit is accepted per cycle; In0_ready and In1_ready are never both high.
REQ-019 Iny_ready = granted(y) AND (count < 2); ready does not depend combinationally on Out_ready.
REQ-020 Latency: a flit accepted at edge N is presented on Out at the cycle after edge N (1 cycle) when the FIFO was empty; ordering is preserved.
REQ-021 Simultaneous push and pop keeps count unchanged; a pop with count 0 is impossible; no push occurs at count 2.
REQ-022 Arbiter state: FSM {IDLE, LOCK0, LOCK1} plus a 1-bit round-robin pointer `last` (last winner).
REQ-023 IDLE, exactly one input valid: that input is granted.
REQ-024 IDLE, both inputs valid: grant goes to the input != last.
REQ-025 On each accepted flit, last is set to the accepting input.
REQ-026 With PKT_LOCK=1, accepting a non-tail flit (bit W-1 = 0) from input i moves IDLE to LOCKi.
REQ-027 In LOCKi, only input i is granted, even if the other input is valid and input i is idle.
REQ-028 Accepting a tail flit from input i in LOCKi returns to IDLE.
REQ-029 A tail flit accepted in IDLE stays in IDLE (single-flit packet).
REQ-030 With PKT_LOCK=0, the FSM stays in IDLE and every flit is arbitrated independently.
REQ-031 No grant and no state change occur while count = 2; LOCKi persists across backpressure.

Reset
REQ-032 While RESET is high at an edge: count=0, FSM=IDLE, last=1 (In0 wins the first contention), Out_valid=0, In0_ready=0, In1_ready=0.
REQ-033 Out_data and S are don't-care while Out_valid=0.
REQ-034 Reset asserted mid-packet or with flits buffered discards all buffered flits and any lock; the first cycle after RESET deasserts behaves as a fresh IDLE state.

Verification
REQ-035 Reset, then both inputs valid continuously, all flits tail=1, Out_ready=1, PKT_LOCK=1 -> Out sources alternate S=0,1,0,1...; Out_valid first high one cycle after the first accept.
REQ-036 In0 sends a 3-flit packet (tail on 3rd) while In1 is valid throughout -> Out shows three S=0 flits in a row, then S=1; In1_ready stays 0 until the In0 tail is accepted.
REQ-037 Out_ready=0 with In0 streaming -> exactly 2 flits accepted, then In0_ready=0; raising Out_ready drains the flits in order with no loss or duplication.
REQ-038 count=1 with Out_ready=1 and an input valid every cycle -> one push and one pop per cycle, Out_valid held 1, full throughput.
REQ-039 RESET pulsed for 1 cycle while in LOCK1 with 2 flits buffered -> next cycle Out_valid=0; with both inputs valid, In0 is granted first.
REQ-040 PKT_LOCK=0 with multi-flit packets on both inputs -> per-flit alternation; a random-stall scoreboard shows per-source order preserved and S matching the true source of every flit.
